bomb_defuse_fsm: RTL and testbench

Game-logic core of the bomb board: accepts debounced controller buttons, checks them against a per-phase secret button sequence, counts strikes, and runs the countdown from a one-cycle seconds tick. It sits directly upstream of the display path; its registered status (phase, strikes, seconds left, armed/defused/exploded) feeds the seven-segment digit decoder and the VGA screen renderer.

---
 rtl/bomb_pkg.sv | 28 ++
 rtl/btn_edge_detect.sv | 19 +
 rtl/bomb_defuse_fsm.sv | 142 ++++++++++++++
 tb/tb_bomb_defuse_fsm.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// Shared types and the default secret button sequence for the bomb board game core.
package bomb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        DEFUSED  = 3'd2,
        EXPLODED = 3'd3
    } state_e;

    typedef enum logic [2:0] {
        RIGHT = 3'd0,
        LEFT  = 3'd1,
        UP    = 3'd2,
        DOWN  = 3'd3,
        A     = 3'd4,
        B     = 3'd5
    } btn_e;

    // Listed from the last entry (phase 3, press 3) down to phase 0, press 0.
    localparam logic [47:0] DEFAULT_CODE = {
        B,     A,    DOWN,  UP,
        A,     B,    A,     B,
        RIGHT, LEFT, RIGHT, LEFT,
        DOWN,  DOWN, UP,    UP
    };

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for debounced button levels. The previous-level register loads
// unconditionally, so a button held through reset never produces a rise afterwards.
module btn_edge_detect #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] btn_q;

    always_ff @(posedge clk) begin
        btn_q <= d_i;
    end

    assign rise_o = d_i & ~btn_q;

endmodule

// File: rtl/bomb_defuse_fsm.sv
// Bomb game core: checks button presses against the per-phase code, counts strikes and
// runs the countdown; all status outputs are registered for the display path.
module bomb_defuse_fsm
    import bomb_pkg::*;
#(
    parameter int NUM_PHASES    = 4,
    parameter int SEQ_LEN       = 4,
    parameter int START_SECONDS = 60,
    parameter int MAX_STRIKES   = 3,
    parameter logic [NUM_PHASES*SEQ_LEN*3-1:0] CODE = DEFAULT_CODE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [5:0]                           btn,
    input  logic                                 tick,
    output logic [2:0]                           state,
    output logic [$clog2(NUM_PHASES+1)-1:0]      phase,
    output logic [$clog2(MAX_STRIKES+1)-1:0]     strikes,
    output logic [$clog2(START_SECONDS+1)-1:0]   seconds_left,
    output logic                                 press_ok,
    output logic                                 press_bad
);

    localparam int PH_W  = $clog2(NUM_PHASES+1);
    localparam int SK_W  = $clog2(MAX_STRIKES+1);
    localparam int SEC_W = $clog2(START_SECONDS+1);
    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    localparam logic [PH_W-1:0]  LAST_PHASE   = PH_W'(NUM_PHASES-1);
    localparam logic [PH_W-1:0]  DONE_PHASE   = PH_W'(NUM_PHASES);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(SEQ_LEN-1);
    localparam logic [SK_W-1:0]  STRIKE_LIMIT = SK_W'(MAX_STRIKES);
    localparam logic [SEC_W-1:0] SEC_INIT     = SEC_W'(START_SECONDS);
    localparam logic [SEC_W-1:0] SEC_ONE      = SEC_W'(1);
    localparam logic [5:0]       ARM_RISE     = 6'(1 << int'(A));

    function automatic logic [2:0] encode(input logic [5:0] v);
        logic [2:0] enc;
        enc = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) enc = 3'(i);
        end
        return enc;
    endfunction

    logic [5:0]       rise;
    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SK_W-1:0]  strikes_q, strikes_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             ok_q, ok_d;
    logic             bad_q, bad_d;
    logic [2:0]       want_code;
    logic             defuse, explode;

    btn_edge_detect #(.W(6)) u_edge (
        .clk    (clk),
        .d_i    (btn),
        .rise_o (rise)
    );

    assign want_code = CODE[(int'(phase_q)*SEQ_LEN + int'(idx_q))*3 +: 3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            strikes_q <= '0;
            sec_q     <= SEC_INIT;
            ok_q      <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            strikes_q <= strikes_d;
            sec_q     <= sec_d;
            ok_q      <= ok_d;
            bad_q     <= bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        strikes_d = strikes_q;
        sec_d     = sec_q;
        ok_d      = 1'b0;
        bad_d     = 1'b0;
        defuse    = 1'b0;
        explode   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise == ARM_RISE) state_d = ARMED;
            end
            ARMED: begin
                if (rise != 6'd0) begin
                    if ($onehot(rise) && (encode(rise) == want_code)) begin
                        ok_d = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
                            if (phase_q == LAST_PHASE) begin
                                phase_d = DONE_PHASE;
                                defuse  = 1'b1;
                            end else begin
                                phase_d = phase_q + 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        bad_d = 1'b1;
                        idx_d = '0;
                        if (strikes_q != STRIKE_LIMIT) strikes_d = strikes_q + 1'b1;
                        if (strikes_d == STRIKE_LIMIT) explode = 1'b1;
                    end
                end
                // The tick still decrements when the press defuses; defuse simply outranks explode.
                if (tick && (sec_q != '0)) begin
                    sec_d = sec_q - 1'b1;
                    if (sec_q == SEC_ONE) explode = 1'b1;
                end
                if (defuse)       state_d = DEFUSED;
                else if (explode) state_d = EXPLODED;
            end
            default: ;
        endcase
    end

    always_comb begin
        state        = state_q;
        phase        = phase_q;
        strikes      = strikes_q;
        seconds_left = sec_q;
        press_ok     = ok_q;
        press_bad    = bad_q;
    end

endmodule

// File: tb/tb_bomb_defuse_fsm.sv
// Directed vector bench for bomb_defuse_fsm: scenario rows are built into a table, then
// applied one clock each and compared against hand-computed outputs.
module tb_bomb_defuse_fsm;

  localparam int S_IDLE = 0;
  localparam int S_ARM  = 1;
  localparam int S_DEF  = 2;
  localparam int S_EXP  = 3;

  localparam int BR = 1;
  localparam int BL = 2;
  localparam int BU = 4;
  localparam int BD = 8;
  localparam int BA = 16;
  localparam int BB = 32;

  localparam int TIMEOUT_NS = 200000;

  typedef struct packed {
    logic [7:0] scen;
    logic       rst;
    logic [5:0] btn;
    logic       tick;
    logic [2:0] st;
    logic [2:0] ph;
    logic [1:0] sk;
    logic [5:0] sec;
    logic       ok;
    logic       bad;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] btn = 6'd0;
  logic       tick = 1'b0;
  logic [2:0] state;
  logic [2:0] phase;
  logic [1:0] strikes;
  logic [5:0] seconds_left;
  logic       press_ok;
  logic       press_bad;

  vec_t vecs[$];
  int   code_tb[16];
  int   cur_scen;
  int   checks = 0;
  int   failures = 0;
  logic done = 1'b0;

  bomb_defuse_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .tick         (tick),
    .state        (state),
    .phase        (phase),
    .strikes      (strikes),
    .seconds_left (seconds_left),
    .press_ok     (press_ok),
    .press_bad    (press_bad)
  );

  always #5 clk = ~clk;

  task automatic add(input int r, input int b, input int t, input int st, input int ph,
                     input int sk, input int sec, input int ok, input int bad);
    vec_t v;
    v.scen = 8'(cur_scen);
    v.rst  = 1'(r);
    v.btn  = 6'(b);
    v.tick = 1'(t);
    v.st   = 3'(st);
    v.ph   = 3'(ph);
    v.sk   = 2'(sk);
    v.sec  = 6'(sec);
    v.ok   = 1'(ok);
    v.bad  = 1'(bad);
    vecs.push_back(v);
  endtask

  task automatic reset_and_arm();
    add(1, 0, 0, S_IDLE, 0, 0, 60, 0, 0);
    add(0, 0, 0, S_IDLE, 0, 0, 60, 0, 0);
    add(0, BA, 0, S_ARM, 0, 0, 60, 0, 0);
    add(0, 0, 0, S_ARM, 0, 0, 60, 0, 0);
  endtask

  // Correct presses 0..n-1 from a fresh arm, each followed by a release row.
  task automatic correct_presses(input int n, input int sk, input int sec);
    for (int k = 0; k < n; k++) begin
      add(0, 1 << code_tb[k], 0, S_ARM, (k + 1) / 4, sk, sec, 1, 0);
      add(0, 0, 0, S_ARM, (k + 1) / 4, sk, sec, 0, 0);
    end
  endtask

  initial begin
    #(TIMEOUT_NS);
    if (!done) begin
      failures++;
      $display("FAIL timeout: bench did not finish within %0d ns", TIMEOUT_NS);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int sec;
    int st;
    int ph;
    code_tb = '{2, 2, 3, 3, 1, 0, 1, 0, 5, 4, 5, 4, 2, 3, 4, 5};

    // 1: A held through reset, then released and pressed; full defuse with 4 ticks.
    cur_scen = 1;
    add(1, BA, 0, S_IDLE, 0, 0, 60, 0, 0);
    add(1, BA, 0, S_IDLE, 0, 0, 60, 0, 0);
    add(0, BA, 0, S_IDLE, 0, 0, 60, 0, 0);
    add(0, 0, 1, S_IDLE, 0, 0, 60, 0, 0);
    add(0, BA, 1, S_ARM, 0, 0, 60, 0, 0);
    add(0, 0, 0, S_ARM, 0, 0, 60, 0, 0);
    sec = 60;
    for (int k = 0; k < 16; k++) begin
      ph = (k == 15) ? 4 : (k + 1) / 4;
      st = (k == 15) ? S_DEF : S_ARM;
      add(0, 1 << code_tb[k], 0, st, ph, 0, sec, 1, 0);
      if (k == 0) add(0, 1 << code_tb[k], 0, st, ph, 0, sec, 0, 0);
      if (k % 4 == 1) begin
        sec = sec - 1;
        add(0, 0, 1, st, ph, 0, sec, 0, 0);
      end else begin
        add(0, 0, 0, st, ph, 0, sec, 0, 0);
      end
    end
    add(0, BA, 1, S_DEF, 4, 0, 56, 0, 0);
    add(0, 0, 1, S_DEF, 4, 0, 56, 0, 0);
    add(0, BR | BL, 0, S_DEF, 4, 0, 56, 0, 0);

    // 2: three strikes, one from a double press; idx restarts after each strike.
    cur_scen = 2;
    reset_and_arm();
    add(0, BU, 0, S_ARM, 0, 0, 60, 1, 0);
    add(0, 0, 0, S_ARM, 0, 0, 60, 0, 0);
    add(0, BD, 0, S_ARM, 0, 1, 60, 0, 1);
    add(0, 0, 0, S_ARM, 0, 1, 60, 0, 0);
    add(0, BU, 0, S_ARM, 0, 1, 60, 1, 0);
    add(0, 0, 0, S_ARM, 0, 1, 60, 0, 0);
    add(0, BR | BL, 0, S_ARM, 0, 2, 60, 0, 1);
    add(0, 0, 0, S_ARM, 0, 2, 60, 0, 0);
    add(0, BU, 0, S_ARM, 0, 2, 60, 1, 0);
    add(0, 0, 0, S_ARM, 0, 2, 60, 0, 0);
    add(0, BU, 0, S_ARM, 0, 2, 60, 1, 0);
    add(0, 0, 0, S_ARM, 0, 2, 60, 0, 0);
    add(0, BR, 0, S_EXP, 0, 3, 60, 0, 1);
    add(0, 0, 0, S_EXP, 0, 3, 60, 0, 0);
    add(0, BU, 1, S_EXP, 0, 3, 60, 0, 0);

    // 3: countdown to zero, explode on the 60th tick, no wrap on the 61st.
    cur_scen = 3;
    reset_and_arm();
    for (int t = 1; t <= 60; t++) add(0, 0, 1, (t == 60) ? S_EXP : S_ARM, 0, 0, 60 - t, 0, 0);
    add(0, 0, 1, S_EXP, 0, 0, 0, 0, 0);

    // 4: last correct press coincides with the final tick: defuse wins.
    cur_scen = 4;
    reset_and_arm();
    correct_presses(15, 0, 60);
    for (int t = 1; t <= 59; t++) add(0, 0, 1, S_ARM, 3, 0, 60 - t, 0, 0);
    add(0, BB, 1, S_DEF, 4, 0, 0, 1, 0);
    add(0, 0, 1, S_DEF, 4, 0, 0, 0, 0);

    // 5: reset mid-phase 2 with two strikes; A pressed during reset does not arm.
    cur_scen = 5;
    reset_and_arm();
    correct_presses(8, 0, 60);
    add(0, BU, 0, S_ARM, 2, 1, 60, 0, 1);
    add(0, 0, 0, S_ARM, 2, 1, 60, 0, 0);
    add(0, BU, 0, S_ARM, 2, 2, 60, 0, 1);
    add(0, 0, 0, S_ARM, 2, 2, 60, 0, 0);
    add(0, BB, 1, S_ARM, 2, 2, 59, 1, 0);
    add(1, BA, 0, S_IDLE, 0, 0, 60, 0, 0);
    add(0, BA, 1, S_IDLE, 0, 0, 60, 0, 0);
    add(0, 0, 0, S_IDLE, 0, 0, 60, 0, 0);
    add(0, BB, 0, S_IDLE, 0, 0, 60, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      rst  = v.rst;
      btn  = v.btn;
      tick = v.tick;
      @(posedge clk);
      #1;
      checks++;
      if ({state, phase, strikes, seconds_left, press_ok, press_bad} !==
          {v.st, v.ph, v.sk, v.sec, v.ok, v.bad}) begin
        failures++;
        $display("FAIL scen%0d row%0d: got state=%0d phase=%0d strikes=%0d sec=%0d ok=%0b bad=%0b, need state=%0d phase=%0d strikes=%0d sec=%0d ok=%0b bad=%0b",
                 v.scen, i, state, phase, strikes, seconds_left, press_ok, press_bad,
                 v.st, v.ph, v.sk, v.sec, v.ok, v.bad);
      end
    end

    @(negedge clk);
    rst  = 1'b1;
    btn  = 6'd0;
    tick = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ((state !== 3'(S_IDLE)) || (phase !== 3'd0) || (strikes !== 2'd0) ||
        (seconds_left !== 6'd60) || (press_ok !== 1'b0) || (press_bad !== 1'b0)) begin
      failures++;
      $display("FAIL reset-state: got state=%0d phase=%0d strikes=%0d sec=%0d ok=%0b bad=%0b",
               state, phase, strikes, seconds_left, press_ok, press_bad);
    end
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
